c3lib_rst_seq_ctrl: RTL and testbench
=====================================

// Module: c3lib_rst_seq_ctrl
// PURPOSE
// - Staged reset sequencer. Drives active-low async reset inputs (rst_n) of downstream set/clear flop cells.
// - Releases NUM_STAGES resets one at a time, in order, spaced by a programmable delay.
// - Asserts all stage resets together when the request drops.
// - Sits directly upstream of flop-cell reset pins. Every stage output is a flop output, so it is glitch-free.
// PARAMETERS
// - NUM_STAGES   4   number of sequenced reset outputs (>=1)
// - CNT_WIDTH    8   width of delay counter and dly_cfg
// PORTS
// - clk           in   1           single clock; all logic on posedge clk
// - rst           in   1           synchronous, active-high block reset
// - seq_req       in   1           level: 1 = release stage resets, 0 = assert all
// - dly_cfg       in   CNT_WIDTH   cycles between releases; sampled on each counter load
// - stage_rst_n   out  NUM_STAGES  active-low resets; bit 0 released first
// - seq_busy      out  1           release sequence in progress
// - seq_done      out  1           all stages released and held
// BEHAVIOUR
// - Reset is synchronous and active-high. While rst=1 at a posedge:
//   - stage_rst_n = '0, seq_busy = 0, seq_done = 0
//   - state = IDLE, counter = 0, stage index = 0
// - All outputs are registered. No combinational path from any input to any output.
// - Effective delay D = (dly_cfg == 0) ? 1 : dly_cfg.
// - FSM states: IDLE, RELEASE, DONE.
// - IDLE: stage_rst_n = '0, seq_busy = 0, seq_done = 0.
//   - seq_req = 1 sampled at edge t0 -> RELEASE. Counter is loaded with D at t0.
// - RELEASE: seq_busy = 1. Counter decrements each cycle.
//   - When counter reaches 0, bit[idx] of stage_rst_n goes 1, idx increments, counter reloads with D (dly_cfg re-sampled).
//   - Stage k releases at edge t0 + (k+1)*D.
//   - The edge that releases stage NUM_STAGES-1 also moves to DONE: seq_busy = 0, seq_done = 1 at that same edge.
// - DONE: stage_rst_n = '1, seq_done = 1. Held while seq_req = 1.
// - seq_req = 0 sampled in RELEASE or DONE, at any edge:
//   - All stage_rst_n bits go 0 at that edge.
//   - seq_busy = 0, seq_done = 0, state = IDLE, idx = 0.
//   - Assertion has priority over a release falling on the same edge.
// - seq_req re-asserted after a drop restarts from stage 0 with a full D.
// - Stage bits are monotonic within a sequence: once released, a bit stays 1 until seq_req drops or rst.
// - Released bits always form a contiguous run from bit 0.
// - Counter never wraps. A reload always occurs at 0, so an underflow is impossible.
// - dly_cfg changes mid-sequence affect only the next reload.
// - rst mid-sequence overrides everything on the next edge and returns to the reset values above.
// STRUCTURE
// - Package c3lib_rst_seq_pkg holds:
//   - typedef enum logic [1:0] {IDLE, RELEASE, DONE} rst_seq_state_t
//   - function eff_dly(): maps 0 to 1.
// - Sub-module c3lib_rst_seq_cnt: loadable down-counter (CNT_WIDTH, clk, rst, load, load_val, zero).
// - Top level holds the FSM, stage index (width $clog2(NUM_STAGES+1)) and the stage_rst_n register.
// TESTING
// - rst=1 for 3 cycles, seq_req=1 held -> stage_rst_n=4'b0000, busy=0, done=0 throughout the reset.
// - dly_cfg=3, seq_req rises at t0 -> stage_rst_n goes 0001@t0+3, 0011@+6, 0111@+9, 1111@+12; done=1 @+12.
// - dly_cfg=0 -> behaves as D=1: 0001,0011,0111,1111 on 4 consecutive edges; done on the 4th.
// - dly_cfg=5, seq_req drops at t0+7 (0001 state) -> 0000 at that edge, busy=0; re-raise -> stage0 @+5 again.
// - Drop seq_req on the exact edge stage 2 would release -> 0000, no transient 0111.
// - dly_cfg=2, change to 6 after stage0 release -> stage1 @ +6 after stage0; assert rst mid-seq -> all outputs 0.

Source files
------------

// File: rtl/c3lib_rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package c3lib_rst_seq_pkg;

  typedef enum logic [1:0] {IDLE, RELEASE, DONE} rst_seq_state_t;

  // A programmed delay of 0 is treated as a single cycle.
  function automatic int unsigned eff_dly(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/c3lib_rst_seq_cnt.sv
// Loadable down-counter that saturates at 0 and flags its final step.
module c3lib_rst_seq_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - CNT_WIDTH'(1);
  end

  // The count reaches 0 on the coming edge, so the release lands exactly D edges after a load.
  assign zero = (cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/c3lib_rst_seq_ctrl.sv
// Staged reset sequencer: releases NUM_STAGES active-low resets in order, spaced by dly_cfg.
module c3lib_rst_seq_ctrl
  import c3lib_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seq_req,
  input  logic [CNT_WIDTH-1:0]  dly_cfg,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_busy,
  output logic                  seq_done
);

  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  rst_seq_state_t        state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [NUM_STAGES-1:0] stage_n;
  logic                  busy_n, done_n;
  logic                  load, zero;
  logic [CNT_WIDTH-1:0]  load_val;

  assign load_val = CNT_WIDTH'(eff_dly(32'(dly_cfg)));

  c3lib_rst_seq_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      stage_rst_n <= '0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      stage_rst_n <= stage_n;
      seq_busy    <= busy_n;
      seq_done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    stage_n = stage_rst_n;
    busy_n  = seq_busy;
    done_n  = seq_done;
    load    = 1'b0;
    case (state)
      IDLE: begin
        stage_n = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        idx_n   = '0;
        if (seq_req) begin
          state_n = RELEASE;
          busy_n  = 1'b1;
          load    = 1'b1;
        end
      end
      RELEASE: begin
        // A dropped request wins over a release due on the same edge.
        if (!seq_req) begin
          state_n = IDLE;
          idx_n   = '0;
          stage_n = '0;
          busy_n  = 1'b0;
          done_n  = 1'b0;
        end else if (zero) begin
          // Shifting in a 1 keeps released bits a contiguous run from bit 0.
          stage_n = (stage_rst_n << 1) | NUM_STAGES'(1);
          idx_n   = idx + IDX_W'(1);
          load    = 1'b1;
          if (idx == IDX_W'(NUM_STAGES - 1)) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!seq_req) begin
          state_n = IDLE;
          idx_n   = '0;
          stage_n = '0;
          busy_n  = 1'b0;
          done_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        stage_n = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_c3lib_rst_seq_ctrl.sv
// Directed bench for c3lib_rst_seq_ctrl with hand-computed expectations.
module tb_c3lib_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       seq_req;
  logic [7:0] dly_cfg;
  logic [3:0] stage_rst_n;
  logic       seq_busy;
  logic       seq_done;

  int total = 0;
  int passed = 0;

  c3lib_rst_seq_ctrl #(.NUM_STAGES(4), .CNT_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .seq_req     (seq_req),
    .dly_cfg     (dly_cfg),
    .stage_rst_n (stage_rst_n),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done)
  );

  always #5 clk = ~clk;

  // Advance n active edges, then settle 1ns before sampling or driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // exp = {stage_rst_n, seq_busy, seq_done}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {stage_rst_n, seq_busy, seq_done};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; seq_req = 1'b1; dly_cfg = 8'd3;
    tick(1); chk("rst_c1", 6'b0000_0_0);
    tick(1); chk("rst_c2", 6'b0000_0_0);
    tick(1); chk("rst_c3", 6'b0000_0_0);
    rst = 1'b0;

    // D=3: t0 is the next edge
    tick(1); chk("d3_t0",  6'b0000_1_0);
    tick(2); chk("d3_t2",  6'b0000_1_0);
    tick(1); chk("d3_s0",  6'b0001_1_0);
    tick(2); chk("d3_t5",  6'b0001_1_0);
    tick(1); chk("d3_s1",  6'b0011_1_0);
    tick(3); chk("d3_s2",  6'b0111_1_0);
    tick(2); chk("d3_t11", 6'b0111_1_0);
    tick(1); chk("d3_s3",  6'b1111_0_1);
    tick(2); chk("d3_hold", 6'b1111_0_1);

    seq_req = 1'b0;
    tick(1); chk("drop_done", 6'b0000_0_0);

    // dly_cfg=0 behaves as D=1
    dly_cfg = 8'd0; seq_req = 1'b1;
    tick(1); chk("d0_t0", 6'b0000_1_0);
    tick(1); chk("d0_s0", 6'b0001_1_0);
    tick(1); chk("d0_s1", 6'b0011_1_0);
    tick(1); chk("d0_s2", 6'b0111_1_0);
    tick(1); chk("d0_s3", 6'b1111_0_1);

    seq_req = 1'b0;
    tick(1); chk("d0_drop", 6'b0000_0_0);

    // D=5, drop at t0+7 while only stage 0 is released, then restart
    dly_cfg = 8'd5; seq_req = 1'b1;
    tick(1); chk("d5_t0", 6'b0000_1_0);
    tick(5); chk("d5_s0", 6'b0001_1_0);
    tick(1);
    seq_req = 1'b0;
    tick(1); chk("d5_drop7", 6'b0000_0_0);
    tick(1); chk("d5_idle", 6'b0000_0_0);
    seq_req = 1'b1;
    tick(1); chk("d5r_t0", 6'b0000_1_0);
    tick(4); chk("d5r_t4", 6'b0000_1_0);
    tick(1); chk("d5r_s0", 6'b0001_1_0);
    tick(5); chk("d5r_s1", 6'b0011_1_0);
    tick(4); chk("d5r_t14", 6'b0011_1_0);
    // drop lands on the stage-2 release edge: no 0111 may appear
    seq_req = 1'b0;
    tick(1); chk("drop_on_rel", 6'b0000_0_0);
    tick(1); chk("drop_on_rel2", 6'b0000_0_0);

    // D=2, then 6 before the stage-0 reload samples it
    dly_cfg = 8'd2; seq_req = 1'b1;
    tick(1); chk("d2_t0", 6'b0000_1_0);
    dly_cfg = 8'd6;
    tick(1); chk("d2_t1", 6'b0000_1_0);
    tick(1); chk("d2_s0", 6'b0001_1_0);
    tick(5); chk("d6_t7", 6'b0001_1_0);
    tick(1); chk("d6_s1", 6'b0011_1_0);
    tick(2);
    rst = 1'b1;
    tick(1); chk("rst_mid", 6'b0000_0_0);
    rst = 1'b0; seq_req = 1'b0;
    tick(2); chk("post_rst", 6'b0000_0_0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
